// File: rtl/lenet_pkg.sv
// Shared definitions for the LeNet classification stages: default widths,
// the argmax FSM state encoding and the most-negative score constant.
package lenet_pkg;

   localparam int DATA_W_DEF = 8;
   localparam int IDX_W_DEF  = 8;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_COLLECT = 2'd1,
      ST_DONE    = 2'd2
   } state_t;

   // Most-negative two's-complement value of a w-bit score.
   function automatic int score_min(input int w);
      return -(1 <<< (w - 1));
   endfunction

   localparam logic signed [DATA_W_DEF-1:0] SCORE_MIN = DATA_W_DEF'(score_min(DATA_W_DEF));

endpackage

// File: rtl/fc_argmax_max_cmp.sv
// Signed score comparator: take_new_o is high when the incoming score beats the
// current maximum, with equal scores resolved towards the lower neuron index.
module max_cmp #(
   parameter int DATA_W = 8,
   parameter int IDX_W  = 8
) (
   input  logic [DATA_W-1:0] new_score_i,
   input  logic [IDX_W-1:0]  new_idx_i,
   input  logic [DATA_W-1:0] cur_score_i,
   input  logic [IDX_W-1:0]  cur_idx_i,
   output logic              take_new_o
);

   logic greater;
   logic equal;

   assign greater    = $signed(new_score_i) > $signed(cur_score_i);
   assign equal      = new_score_i == cur_score_i;
   assign take_new_o = greater || (equal && (new_idx_i < cur_idx_i));

endmodule

// File: rtl/fc_argmax.sv
// Captures the serial fully-connected neuron stream into a score vector and
// tracks the running argmax; reports class index/score once the layer is done.
module fc_argmax
   import lenet_pkg::*;
#(
   parameter int NEURON_NUM = 10,
   parameter int DATA_W     = DATA_W_DEF,
   parameter int IDX_W      = IDX_W_DEF
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         start,
   input  logic                         in_valid,
   input  logic [DATA_W-1:0]            in_data,
   input  logic [IDX_W-1:0]             in_index,
   input  logic                         in_last,
   output logic [DATA_W*NEURON_NUM-1:0] score_vec,
   output logic [IDX_W-1:0]             class_idx,
   output logic [DATA_W-1:0]            class_score,
   output logic                         busy,
   output logic                         done,
   output logic                         err,
   output logic [1:0]                   dbg_state_o
);

   localparam logic [DATA_W-1:0] MAX_INIT = DATA_W'(score_min(DATA_W));
   localparam logic [IDX_W-1:0]  N_LAST   = IDX_W'(NEURON_NUM);

   state_t                       state_q,     state_d;
   logic [DATA_W*NEURON_NUM-1:0] score_vec_q, score_vec_d;
   logic [NEURON_NUM-1:0]        mask_q,      mask_d;
   logic [IDX_W-1:0]             count_q,     count_d;
   logic [DATA_W-1:0]            max_q,       max_d;
   logic [IDX_W-1:0]             class_idx_q, class_idx_d;
   logic                         err_q,       err_d;

   logic in_range;
   logic dup;
   logic accept;
   logic take_new;

   max_cmp #(
      .DATA_W (DATA_W),
      .IDX_W  (IDX_W)
   ) u_max_cmp (
      .new_score_i (in_data),
      .new_idx_i   (in_index),
      .cur_score_i (max_q),
      .cur_idx_i   (class_idx_q),
      .take_new_o  (take_new)
   );

   // start always wins over a coincident sample, so it gates acceptance.
   always_comb begin
      in_range = in_index < N_LAST;
      dup      = 1'b0;
      for (int k = 0; k < NEURON_NUM; k++) begin
         if ((in_index == IDX_W'(k)) && mask_q[k]) dup = 1'b1;
      end
      accept = (state_q == ST_COLLECT) && in_valid && !start && in_range && !dup;
   end

   always_comb begin
      state_d     = state_q;
      score_vec_d = score_vec_q;
      mask_d      = mask_q;
      count_d     = count_q;
      max_d       = max_q;
      class_idx_d = class_idx_q;
      err_d       = err_q;

      if (start) begin
         state_d     = ST_COLLECT;
         score_vec_d = '0;
         mask_d      = '0;
         count_d     = '0;
         max_d       = MAX_INIT;
         class_idx_d = '0;
         err_d       = 1'b0;
      end else if ((state_q == ST_COLLECT) && in_valid) begin
         if (accept) begin
            for (int k = 0; k < NEURON_NUM; k++) begin
               if (in_index == IDX_W'(k)) begin
                  score_vec_d[k*DATA_W +: DATA_W] = in_data;
                  mask_d[k]                       = 1'b1;
               end
            end
            count_d = count_q + IDX_W'(1);
            if (take_new) begin
               max_d       = in_data;
               class_idx_d = in_index;
            end
         end else begin
            err_d = 1'b1;
         end

         // A short layer (in_last before every slot arrived) is flagged.
         if ((accept && (count_d == N_LAST)) || in_last) begin
            state_d = ST_DONE;
            if (count_d != N_LAST) err_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         score_vec_q <= '0;
         mask_q      <= '0;
         count_q     <= '0;
         max_q       <= MAX_INIT;
         class_idx_q <= '0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         score_vec_q <= score_vec_d;
         mask_q      <= mask_d;
         count_q     <= count_d;
         max_q       <= max_d;
         class_idx_q <= class_idx_d;
         err_q       <= err_d;
      end
   end

   // The max register idles at the most-negative value; hide it until a run starts.
   assign class_score = (state_q == ST_IDLE) ? '0 : max_q;
   assign score_vec   = score_vec_q;
   assign class_idx   = class_idx_q;
   assign busy        = state_q == ST_COLLECT;
   assign done        = state_q == ST_DONE;
   assign err         = err_q;
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_fc_argmax.sv
// Bench for fc_argmax: table-driven streams, hand-written corner sequences and
// randomized streams checked against a slot-array reference model.
module tb_fc_argmax;
   import lenet_pkg::*;

   localparam int NN = 10;
   localparam int DW = 8;
   localparam int IW = 8;
   localparam int VW = DW * NN;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic          in_valid;
   logic [DW-1:0] in_data;
   logic [IW-1:0] in_index;
   logic          in_last;
   logic [VW-1:0] score_vec;
   logic [IW-1:0] class_idx;
   logic [DW-1:0] class_score;
   logic          busy;
   logic          done;
   logic          err;
   logic [1:0]    dbg_state;

   fc_argmax #(
      .NEURON_NUM (NN),
      .DATA_W     (DW),
      .IDX_W      (IW)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .in_valid    (in_valid),
      .in_data     (in_data),
      .in_index    (in_index),
      .in_last     (in_last),
      .score_vec   (score_vec),
      .class_idx   (class_idx),
      .class_score (class_score),
      .busy        (busy),
      .done        (done),
      .err         (err),
      .dbg_state_o (dbg_state)
   );

   always #5 clk = ~clk;

   int n_vec  = 0;
   int n_miss = 0;

   task automatic check(input string name, input logic [VW-1:0] got, input logic [VW-1:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   // Reference model: which slots arrived, their values, and the run status.
   bit            m_has[NN];
   logic [DW-1:0] m_val[NN];
   int            m_cnt;
   bit            m_err;
   bit            m_done;

   function automatic void model_clear();
      for (int k = 0; k < NN; k++) begin
         m_has[k] = 1'b0;
         m_val[k] = '0;
      end
      m_cnt  = 0;
      m_err  = 1'b0;
      m_done = 1'b0;
   endfunction

   function automatic void model_sample(input int idx, input logic [DW-1:0] d, input bit last);
      if (m_done) return;
      if (idx >= NN) m_err = 1'b1;
      else if (m_has[idx]) m_err = 1'b1;
      else begin
         m_has[idx] = 1'b1;
         m_val[idx] = d;
         m_cnt++;
      end
      if (m_cnt == NN || last) begin
         m_done = 1'b1;
         if (m_cnt != NN) m_err = 1'b1;
      end
   endfunction

   // Winner = highest received score; lowest index holding it; index 0 if nothing beats the floor.
   function automatic void model_best(output int bidx, output logic [DW-1:0] bscore);
      int best;
      best = SCORE_MIN;
      for (int k = 0; k < NN; k++)
         if (m_has[k] && $signed(m_val[k]) > best) best = $signed(m_val[k]);
      bidx = 0;
      if (best != SCORE_MIN)
         for (int k = NN - 1; k >= 0; k--)
            if (m_has[k] && $signed(m_val[k]) == best) bidx = k;
      bscore = DW'(best);
   endfunction

   function automatic logic [VW-1:0] model_vec();
      logic [VW-1:0] v;
      v = '0;
      for (int k = 0; k < NN; k++) if (m_has[k]) v[k*DW +: DW] = m_val[k];
      return v;
   endfunction

   task automatic check_model(input string tag);
      int            bidx;
      logic [DW-1:0] bscore;
      check({tag, "_done"}, VW'(done), VW'(m_done));
      check({tag, "_busy"}, VW'(busy), VW'(!m_done));
      if (m_done) begin
         model_best(bidx, bscore);
         check({tag, "_err"},   VW'(err),         VW'(m_err));
         check({tag, "_idx"},   VW'(class_idx),   VW'(bidx));
         check({tag, "_score"}, VW'(class_score), VW'(bscore));
         check({tag, "_vec"},   score_vec,        model_vec());
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic run_sample(input int idx, input logic [DW-1:0] d, input bit last);
      in_valid = 1'b1;
      in_index = IW'(idx);
      in_data  = d;
      in_last  = last;
      tick();
      in_valid = 1'b0;
      in_last  = 1'b0;
      model_sample(idx, d, last);
   endtask

   typedef struct {
      logic [DW-1:0] vals[NN];
      bit            rev;
      int            n_send;
      bit            use_last;
      int            exp_idx;
      logic [DW-1:0] exp_score;
      bit            exp_err;
   } vec_t;

   vec_t tbl[6];

   initial begin
      #2_000_000;
      $display("FAIL timeout: simulation did not reach the summary");
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0; in_index = '0; in_last = 1'b0;

      tbl[0] = '{vals: '{8'd3, 8'd7, 8'd1, 8'd9, 8'd2, 8'd9, 8'd0, 8'd5, 8'd4, 8'd8},
                 rev: 0, n_send: 10, use_last: 1, exp_idx: 3, exp_score: 8'd9, exp_err: 0};
      tbl[1] = '{vals: '{8'd3, 8'd7, 8'd1, 8'd9, 8'd2, 8'd9, 8'd0, 8'd5, 8'd4, 8'd8},
                 rev: 1, n_send: 10, use_last: 1, exp_idx: 3, exp_score: 8'd9, exp_err: 0};
      tbl[2] = '{vals: '{8'd3, 8'd7, 8'd1, 8'd9, 8'd2, 8'd9, 8'd0, 8'd5, 8'd4, 8'd8},
                 rev: 0, n_send: 6, use_last: 1, exp_idx: 3, exp_score: 8'd9, exp_err: 1};
      tbl[3] = '{vals: '{default: 8'h80},
                 rev: 0, n_send: 10, use_last: 1, exp_idx: 0, exp_score: 8'h80, exp_err: 0};
      tbl[4] = '{vals: '{8'hFB, 8'hFD, 8'hF9, 8'hFD, 8'h80, 8'hCE, 8'hF7, 8'hFC, 8'hFD, 8'hEC},
                 rev: 1, n_send: 10, use_last: 0, exp_idx: 1, exp_score: 8'hFD, exp_err: 0};
      tbl[5] = '{vals: '{8'd10, 8'd127, 8'hFF, 8'd127, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'h80},
                 rev: 0, n_send: 10, use_last: 0, exp_idx: 1, exp_score: 8'd127, exp_err: 0};

      repeat (3) tick();
      rst = 1'b0;
      check("rst_busy",  VW'(busy), '0);
      check("rst_done",  VW'(done), '0);
      check("rst_err",   VW'(err), '0);
      check("rst_idx",   VW'(class_idx), '0);
      check("rst_score", VW'(class_score), '0);
      check("rst_vec",   score_vec, '0);

      for (int t = 0; t < 6; t++) begin
         model_clear();
         do_start();
         check($sformatf("tbl%0d_busy0", t), VW'(busy), VW'(1));
         for (int p = 0; p < tbl[t].n_send; p++) begin
            int idx;
            idx = tbl[t].rev ? (NN - 1 - p) : p;
            if (p == tbl[t].n_send - 1) check($sformatf("tbl%0d_early", t), VW'(done), '0);
            run_sample(idx, tbl[t].vals[idx], tbl[t].use_last && (p == tbl[t].n_send - 1));
         end
         check($sformatf("tbl%0d_done", t),  VW'(done),        VW'(1));
         check($sformatf("tbl%0d_idx", t),   VW'(class_idx),   VW'(tbl[t].exp_idx));
         check($sformatf("tbl%0d_score", t), VW'(class_score), VW'(tbl[t].exp_score));
         check($sformatf("tbl%0d_err", t),   VW'(err),         VW'(tbl[t].exp_err));
         check($sformatf("tbl%0d_vec", t),   score_vec,        model_vec());
      end

      // Out-of-range index and a duplicate index mid-stream.
      model_clear();
      do_start();
      for (int k = 0; k < 4; k++) run_sample(k, DW'(k + 5), 1'b0);
      run_sample(12, 8'd50, 1'b0);
      run_sample(4, 8'd20, 1'b0);
      run_sample(4, 8'd90, 1'b0);
      run_sample(5, 8'd1, 1'b0);
      run_sample(6, 8'd2, 1'b0);
      run_sample(7, 8'd3, 1'b0);
      run_sample(8, 8'd4, 1'b0);
      run_sample(9, 8'd9, 1'b0);
      check("dup_err",   VW'(err),              VW'(1));
      check("dup_slot4", VW'(score_vec[39:32]), VW'(20));
      check("dup_idx",   VW'(class_idx),        VW'(4));
      check_model("dup");

      // Restart after a partial stream of large values.
      model_clear();
      do_start();
      for (int k = 0; k < 4; k++) run_sample(k, 8'd100, 1'b0);
      do_start();
      model_clear();
      check("rs_done0", VW'(done), '0);
      for (int k = 0; k < NN; k++) run_sample(k, DW'(k + 1), k == NN - 1);
      check("rs_idx",   VW'(class_idx),   VW'(9));
      check("rs_score", VW'(class_score), VW'(10));
      check("rs_err",   VW'(err),         '0);
      check_model("rs");

      // Reset mid-collection, then start coincident with a sample.
      model_clear();
      do_start();
      for (int k = 0; k < 3; k++) run_sample(k, 8'd60, 1'b0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("mrst_busy",  VW'(busy), '0);
      check("mrst_done",  VW'(done), '0);
      check("mrst_err",   VW'(err), '0);
      check("mrst_idx",   VW'(class_idx), '0);
      check("mrst_score", VW'(class_score), '0);
      check("mrst_vec",   score_vec, '0);
      do_start();
      for (int k = 0; k < 3; k++) run_sample(k, 8'd50, 1'b0);
      start = 1'b1; in_valid = 1'b1; in_index = '0; in_data = 8'd99;
      tick();
      start = 1'b0; in_valid = 1'b0;
      model_clear();
      for (int k = 0; k < NN; k++) run_sample(k, DW'(k + 1), 1'b0);
      check("sv_err",   VW'(err),            '0);
      check("sv_slot0", VW'(score_vec[7:0]), VW'(1));
      check_model("sv");

      // Randomized streams with ties, bad indices, duplicates and early in_last.
      for (int r = 0; r < 30; r++) begin
         int guard;
         model_clear();
         do_start();
         guard = 0;
         while (!m_done && guard < 40) begin
            int            idx;
            logic [DW-1:0] d;
            bit            last;
            idx  = $urandom_range(0, NN + 1);
            d    = ($urandom_range(0, 1) == 1) ? DW'($urandom) : DW'($urandom_range(0, 3));
            last = ($urandom_range(0, 15) == 0) || (guard == 39);
            check($sformatf("rnd%0d_notdone", r), VW'(done), '0);
            run_sample(idx, d, last);
            guard++;
         end
         check_model($sformatf("rnd%0d", r));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
